operand_mux_pipe: RTL and testbench

- Parametrised N-channel operand selector with a registered output stage and a 2-entry skid buffer on a valid/ready handshake.
- Next generation of the EX-stage operand/forwarding muxes.
  - Replaces the fixed 2/3/4-way combinational selects.
  - Defines a deterministic result for out-of-range selects.
  - Supports back-pressure from a stalled downstream stage and a pipeline flush.

---
 rtl/operand_mux_pipe_pkg.sv | 21 ++
 rtl/operand_mux_pipe_mux_n.sv | 36 +++
 rtl/operand_mux_pipe.sv | 126 ++++++++++++
 tb/tb_operand_mux_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_mux_pipe_pkg.sv
// Shared constants for the EX-stage operand selector: FSM encodings,
// forwarding channel indices and the default datapath width.
`ifndef OPERAND_MUX_PIPE_PKG_SV
`define OPERAND_MUX_PIPE_PKG_SV
package operand_mux_pipe_pkg;

  typedef enum logic [1:0] {
    OPMUX_EMPTY = 2'b00,
    OPMUX_BUSY  = 2'b01,
    OPMUX_FULL  = 2'b10
  } opmux_state_t;

  // Forwarding sources double as channel indices into the selector
  localparam int SEL_FORWARD_RAW = 0;
  localparam int SEL_FORWARD_EX  = 1;
  localparam int SEL_FORWARD_MEM = 2;

  localparam int DEFAULT_WORD_WIDTH = 32;

endpackage
`endif

// File: rtl/operand_mux_pipe_mux_n.sv
// Combinational N-way word select; out-of-range selects yield CONSTANT
// and raise err. Reusable anywhere a bounded forwarding mux is needed.
module mux_n #(
  parameter int WORD_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int CONSTANT   = 29
) (
  input  logic [CHANNELS*WORD_WIDTH-1:0] data,
  input  logic [SEL_WIDTH-1:0]           sel,
  output logic [WORD_WIDTH-1:0]          word,
  output logic                           err
);

  localparam logic [WORD_WIDTH-1:0] CONST_WORD = WORD_WIDTH'(CONSTANT);

  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("mux_n: CHANNELS=%0d outside 2..16", CHANNELS);
  end
  if ((1 << SEL_WIDTH) < CHANNELS) begin : g_bad_sel_width
    $error("mux_n: SEL_WIDTH=%0d cannot address %0d channels", SEL_WIDTH, CHANNELS);
  end

  // Default to the out-of-range result so every sel value is fully assigned
  always_comb begin
    word = CONST_WORD;
    err  = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        word = data[k*WORD_WIDTH +: WORD_WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_mux_pipe.sv
// Registered operand selector with a 2-entry skid buffer on valid/ready.
// Define OPERAND_MUX_ERRCNT_EN to build the saturating out-of-range counter.
module operand_mux_pipe
  import operand_mux_pipe_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CHANNELS   = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int CONSTANT   = 29
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*WORD_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]           in_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [WORD_WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]           out_sel,
  output logic                           out_sel_err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     err_count
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  err;
  } beat_t;

  opmux_state_t          state;
  beat_t                 main_q;
  beat_t                 skid_q;
  beat_t                 new_beat;
  logic [WORD_WIDTH-1:0] sel_word;
  logic                  sel_err;
  logic                  accept;
  logic                  emit;

  mux_n #(
    .WORD_WIDTH (WORD_WIDTH),
    .CHANNELS   (CHANNELS),
    .SEL_WIDTH  (SEL_WIDTH),
    .CONSTANT   (CONSTANT)
  ) u_mux (
    .data (in_data),
    .sel  (in_sel),
    .word (sel_word),
    .err  (sel_err)
  );

  assign new_beat = '{data: sel_word, sel: in_sel, err: sel_err};
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // in_ready and out_valid are kept as flops that track the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OPMUX_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= OPMUX_EMPTY;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        OPMUX_EMPTY: begin
          if (accept) begin
            main_q    <= new_beat;
            state     <= OPMUX_BUSY;
            out_valid <= 1'b1;
          end
        end
        OPMUX_BUSY: begin
          if (accept && emit) begin
            main_q <= new_beat;
          end else if (accept) begin
            skid_q   <= new_beat;
            state    <= OPMUX_FULL;
            in_ready <= 1'b0;
          end else if (emit) begin
            state     <= OPMUX_EMPTY;
            out_valid <= 1'b0;
          end
        end
        OPMUX_FULL: begin
          if (emit) begin
            main_q   <= skid_q;
            state    <= OPMUX_BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= OPMUX_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data    = main_q.data;
  assign out_sel     = main_q.sel;
  assign out_sel_err = main_q.err;

`ifdef OPERAND_MUX_ERRCNT_EN
  // Beats dropped by a flush are never counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (flush) begin
      err_count <= 8'd0;
    end else if (accept && sel_err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed and scoreboard-checked bench for operand_mux_pipe built with
// CHANNELS=3 so that sel=3 exercises the out-of-range path.
module tb_operand_mux_pipe;

`ifdef OPERAND_MUX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [95:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_sel_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_count;

  int total;
  int bad;

  logic [31:0] ch [3];

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } beat_t;

  operand_mux_pipe #(
    .WORD_WIDTH (32),
    .CHANNELS   (3),
    .SEL_WIDTH  (2),
    .CONSTANT   (29)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_sel_err (out_sel_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic ordy, input logic fl);
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    in_data   = {ch[2], ch[1], ch[0]};
  endtask

  task automatic test_reset();
    ch[0] = 32'h11; ch[1] = 32'h22; ch[2] = 32'h33;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (2) cyc();
    total++;
    if ({out_valid, in_ready, out_data, out_sel, out_sel_err, err_count} !== {1'b0, 1'b1, 32'h0, 2'd0, 1'b0, 8'd0}) begin
      bad++;
      $display("[TB] FAIL reset_state got v=%b r=%b d=%h s=%0d e=%b c=%0d exp v=0 r=1 d=0 s=0 e=0 c=0",
               out_valid, in_ready, out_data, out_sel, out_sel_err, err_count);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_select();
    logic [1:0]  sels [4];
    logic [31:0] exp_d [4];
    logic        exp_e [4];
    sels  = '{2'd2, 2'd0, 2'd3, 2'd1};
    exp_d = '{32'h33, 32'h11, 32'd29, 32'h22};
    exp_e = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, sels[i], 1'b1, 1'b0);
      cyc();
      total++;
      if ({out_valid, in_ready, out_data, out_sel, out_sel_err} !== {1'b1, 1'b1, exp_d[i], sels[i], exp_e[i]}) begin
        bad++;
        $display("[TB] FAIL basic_beat%0d got v=%b r=%b d=%h s=%0d e=%b exp v=1 r=1 d=%h s=%0d e=%b",
                 i, out_valid, in_ready, out_data, out_sel, out_sel_err, exp_d[i], sels[i], exp_e[i]);
      end
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    cyc();
    total++;
    if ({out_valid, err_count} !== {1'b0, (ERRCNT ? 8'd1 : 8'd0)}) begin
      bad++;
      $display("[TB] FAIL basic_drain got v=%b c=%0d exp v=0 c=%0d", out_valid, err_count, ERRCNT ? 1 : 0);
    end
  endtask

  task automatic test_back_pressure();
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    cyc();
    total++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, 32'h11}) begin
      bad++;
      $display("[TB] FAIL bp_first got v=%b r=%b d=%h exp v=1 r=1 d=11", out_valid, in_ready, out_data);
    end
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    cyc();
    total++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 32'h11}) begin
      bad++;
      $display("[TB] FAIL bp_skid got v=%b r=%b d=%h exp v=1 r=0 d=11", out_valid, in_ready, out_data);
    end
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    cyc();
    total++;
    if ({out_valid, in_ready, out_data, out_sel} !== {1'b1, 1'b0, 32'h11, 2'd0}) begin
      bad++;
      $display("[TB] FAIL bp_stall got v=%b r=%b d=%h s=%0d exp v=1 r=0 d=11 s=0", out_valid, in_ready, out_data, out_sel);
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    cyc();
    total++;
    if ({out_valid, in_ready, out_data, out_sel} !== {1'b1, 1'b1, 32'h22, 2'd1}) begin
      bad++;
      $display("[TB] FAIL bp_second got v=%b r=%b d=%h s=%0d exp v=1 r=1 d=22 s=1", out_valid, in_ready, out_data, out_sel);
    end
    cyc();
    total++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL bp_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_out_of_range();
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    cyc();
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    cyc();
    total++;
    if ({out_valid, out_data, out_sel, out_sel_err, err_count} !== {1'b1, 32'd29, 2'd3, 1'b1, (ERRCNT ? 8'd1 : 8'd0)}) begin
      bad++;
      $display("[TB] FAIL oor_first got v=%b d=%0d s=%0d e=%b c=%0d exp v=1 d=29 s=3 e=1 c=%0d",
               out_valid, out_data, out_sel, out_sel_err, err_count, ERRCNT ? 1 : 0);
    end
    repeat (299) cyc();
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    cyc();
    total++;
    if (err_count !== (ERRCNT ? 8'd255 : 8'd0)) begin
      bad++;
      $display("[TB] FAIL oor_saturate got c=%0d exp c=%0d", err_count, ERRCNT ? 255 : 0);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    cyc();
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    repeat (2) cyc();
    total++;
    if ({out_valid, in_ready, err_count} !== {1'b1, 1'b0, (ERRCNT ? 8'd2 : 8'd0)}) begin
      bad++;
      $display("[TB] FAIL flush_fill got v=%b r=%b c=%0d exp v=1 r=0 c=%0d", out_valid, in_ready, err_count, ERRCNT ? 2 : 0);
    end
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b1);
    cyc();
    total++;
    if ({out_valid, in_ready, err_count} !== {1'b0, 1'b1, 8'd0}) begin
      bad++;
      $display("[TB] FAIL flush_now got v=%b r=%b c=%0d exp v=0 r=1 c=0", out_valid, in_ready, err_count);
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (2) cyc();
    total++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL flush_after got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    cyc();
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, out_data, out_sel, out_sel_err} !== {1'b0, 1'b1, 32'h0, 2'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL areset_now got v=%b r=%b d=%h s=%0d e=%b exp v=0 r=1 d=0 s=0 e=0",
               out_valid, in_ready, out_data, out_sel, out_sel_err);
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    #8;
    rst_n = 1'b1;
    cyc();
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    cyc();
    total++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 32'h33, 2'd2}) begin
      bad++;
      $display("[TB] FAIL areset_first got v=%b d=%h s=%0d exp v=1 d=33 s=2", out_valid, out_data, out_sel);
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    cyc();
  endtask

  task automatic test_random();
    beat_t       q [$];
    beat_t       b;
    logic [7:0]  cnt_exp;
    logic        v, ordy, fl, acc, emt;
    logic [1:0]  s;
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
    cyc();
    cnt_exp = 8'd0;
    for (int n = 0; n < 3000; n++) begin
      total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        bad++;
        $display("[TB] FAIL rnd_hs cyc%0d got v=%b r=%b exp v=%b r=%b",
                 n, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        total++;
        if ({out_data, out_sel, out_sel_err} !== {q[0].d, q[0].s, q[0].e}) begin
          bad++;
          $display("[TB] FAIL rnd_data cyc%0d got d=%h s=%0d e=%b exp d=%h s=%0d e=%b",
                   n, out_data, out_sel, out_sel_err, q[0].d, q[0].s, q[0].e);
        end
      end
      total++;
      if (err_count !== (ERRCNT ? cnt_exp : 8'd0)) begin
        bad++;
        $display("[TB] FAIL rnd_errcnt cyc%0d got c=%0d exp c=%0d", n, err_count, ERRCNT ? cnt_exp : 8'd0);
      end
      for (int k = 0; k < 3; k++) ch[k] = $urandom;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      s    = 2'($urandom_range(0, 3));
      applyStimulus(v, s, ordy, fl);
      acc = v && (q.size() < 2) && !fl;
      emt = ordy && (q.size() > 0) && !fl;
      b.s = s;
      b.e = (s == 2'd3);
      b.d = (s == 2'd3) ? 32'd29 : ch[s];
      cyc();
      if (fl) begin
        q.delete();
        cnt_exp = 8'd0;
      end else begin
        if (emt) void'(q.pop_front());
        if (acc) begin
          q.push_back(b);
          if (b.e && cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
        end
      end
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    cyc();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_select();
    test_back_pressure();
    test_out_of_range();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
